afpm_host_driver: RTL and testbench

- Host-side initiator for the byte-serial approximate FP16 multiplier (ui_in/uio_in/uo_out pin protocol).
- Accepts two 16-bit FP16 operands on a valid/ready interface and sends a start byte, then the operand bytes low-first, on the multiplier's input lanes.
- Waits the fixed responder latency, captures the two result bytes low-first from the multiplier's output lane, and presents the 16-bit result on a valid/ready interface.
- Used on the FPGA/bench side to drive the tapeout pins and to exercise the multiplier.

---
 rtl/afpm_host_driver.sv | 118 +++++++++++
 tb/tb_afpm_host_driver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afpm_host_driver.sv
// Host-side initiator for the byte-serial FP16 multiplier.
// Ports: in_* operand handshake, out_* result handshake, busy,
// txn_count, and the dut_ui/dut_uio/dut_uo pin lanes.
module afpm_host_driver #(
  parameter logic [7:0]  START_BYTE = 8'h01,
  parameter int unsigned RESP_LAT   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        busy,
  output logic [15:0] txn_count,
  output logic [7:0]  dut_ui,
  output logic [7:0]  dut_uio,
  input  logic [7:0]  dut_uo
);

  localparam logic [7:0] LAT = RESP_LAT[7:0];

  typedef enum logic [2:0] {
    IDLE,
    SEND_LO,
    SEND_HI,
    WAIT,
    CAP_HI
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  ui_d, uio_d;
  logic [15:0] res_d, tc_d;
  logic        ov_d;

  assign in_ready = (state_q == IDLE) && !out_valid;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    ui_d    = 8'h00;
    uio_d   = 8'h00;
    res_d   = out_result;
    tc_d    = txn_count;
    ov_d    = out_valid;
    if (out_valid && out_ready)
      ov_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          ui_d    = START_BYTE;
          state_d = SEND_LO;
        end
      end
      SEND_LO: begin
        ui_d    = a_q[7:0];
        uio_d   = b_q[7:0];
        state_d = SEND_HI;
      end
      SEND_HI: begin
        ui_d    = a_q[15:8];
        uio_d   = b_q[15:8];
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAT) begin
          res_d[7:0] = dut_uo;
          state_d    = CAP_HI;
        end
      end
      CAP_HI: begin
        res_d[15:8] = dut_uo;
        ov_d        = 1'b1;
        tc_d        = txn_count + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      cnt_q      <= 8'd0;
      dut_ui     <= 8'h00;
      dut_uio    <= 8'h00;
      out_result <= 16'h0000;
      out_valid  <= 1'b0;
      txn_count  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      dut_ui     <= ui_d;
      dut_uio    <= uio_d;
      out_result <= res_d;
      out_valid  <= ov_d;
      txn_count  <= tc_d;
    end
  end

endmodule

// File: tb/tb_afpm_host_driver.sv
// Bench for afpm_host_driver with a behavioural pin responder.
// Vectors, random transactions, backpressure, reset abort, wrap.
module tb_afpm_host_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0;
  logic [15:0] in_b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        busy;
  logic [15:0] txn_count;
  logic [7:0]  dut_ui;
  logic [7:0]  dut_uio;
  logic [7:0]  dut_uo;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = 16'h0;

  always #5 clk = ~clk;

  afpm_host_driver dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy),
    .txn_count(txn_count),
    .dut_ui(dut_ui), .dut_uio(dut_uio), .dut_uo(dut_uo)
  );

  // simplified FP16 product: truncating mantissa, flush/saturate
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, e, m;
    longint p;
    logic s;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 0 || eb == 0) return {s, 15'h0};
    p = longint'(1024 + int'(a[9:0])) * longint'(1024 + int'(b[9:0]));
    e = ea + eb - 15;
    if (p >= 64'd2097152) begin
      m = int'((p >> 11) & 1023);
      e = e + 1;
    end else begin
      m = int'((p >> 10) & 1023);
    end
    if (e <= 0) return {s, 15'h0};
    if (e >= 31) return {s, 15'h7C00};
    return {s, e[4:0], m[9:0]};
  endfunction

  // responder: start at D1, low bytes D2, high bytes D3,
  // result low byte presented for D11, high byte for D12
  bit         scripted = 1'b0;
  logic [7:0] scr_lo = 8'h0;
  logic [7:0] scr_hi = 8'h0;
  int         rp;
  int         rcnt;
  logic [15:0] ra, rb;
  logic [7:0] uo_r;
  assign dut_uo = uo_r;

  always @(posedge clk) begin
    if (!rst_n) begin
      rp   <= 0;
      rcnt <= 0;
      uo_r <= 8'h00;
    end else begin
      case (rp)
        0: begin
          uo_r <= 8'h00;
          if (dut_ui != 8'h00) rp <= 1;
        end
        1: begin
          ra[7:0] <= dut_ui;
          rb[7:0] <= dut_uio;
          rp      <= 2;
        end
        2: begin
          ra[15:8] <= dut_ui;
          rb[15:8] <= dut_uio;
          rcnt     <= 0;
          rp       <= 3;
        end
        3: begin
          if (rcnt == 6) begin
            uo_r <= scripted ? scr_lo : fmul(ra, rb)[7:0];
            rp   <= 4;
          end else begin
            rcnt <= rcnt + 1;
          end
        end
        default: begin
          uo_r <= scripted ? scr_hi : fmul(ra, rb)[15:8];
          rp   <= 0;
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    int guard;
    logic [7:0] eu, eio;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", in_ready, 1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      eu  = (k == 0) ? 8'h01 : (k == 1) ? a[7:0] : (k == 2) ? a[15:8] : 8'h00;
      eio = (k == 1) ? b[7:0] : (k == 2) ? b[15:8] : 8'h00;
      chk($sformatf("ui_k%0d", k), dut_ui, eu);
      chk($sformatf("uio_k%0d", k), dut_uio, eio);
      chk($sformatf("ov_k%0d", k), out_valid, (k == 12));
      chk($sformatf("busy_k%0d", k), busy, (k < 12));
    end
    exp_cnt = exp_cnt + 16'd1;
    chk("result", out_result, exp);
    chk("txn_count", txn_count, exp_cnt);
    chk("ready_while_valid", in_ready, 0);
  endtask

  task automatic consume(input logic [15:0] exp);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("ov_cleared", out_valid, 0);
    chk("ready_after", in_ready, 1);
    chk("result_kept", out_result, exp);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          scr;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [15:0] ra_, rb_, e_;
    vt[0] = '{16'h3C00, 16'h3C00, 1'b0, 8'h00, 8'h00, 16'h3C00};
    vt[1] = '{16'hBC00, 16'h3C00, 1'b0, 8'h00, 8'h00, 16'hBC00};
    vt[2] = '{16'h4000, 16'h4200, 1'b0, 8'h00, 8'h00, 16'h4600};
    vt[3] = '{16'h1111, 16'h2222, 1'b1, 8'h34, 8'h12, 16'h1234};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0 || i == 19) begin
        chk("idle_ui", dut_ui, 0);
        chk("idle_uio", dut_uio, 0);
        chk("idle_ov", out_valid, 0);
        chk("idle_ready", in_ready, 1);
        chk("idle_cnt", txn_count, 0);
        chk("idle_busy", busy, 0);
      end
    end

    for (int i = 0; i < 4; i++) begin
      scripted = vt[i].scr;
      scr_lo = vt[i].lo;
      scr_hi = vt[i].hi;
      run_txn(vt[i].a, vt[i].b, vt[i].exp);
      consume(vt[i].exp);
    end
    scripted = 1'b0;

    // backpressure: result held, new operands refused
    run_txn(16'h4000, 16'h4000, 16'h4400);
    in_valid = 1'b1;
    in_a = 16'h3C00;
    in_b = 16'h3C00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ov", out_valid, 1);
      chk("bp_res", out_result, 16'h4400);
      chk("bp_ready", in_ready, 0);
      chk("bp_busy", busy, 0);
      chk("bp_ui", dut_ui, 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_ov_clr", out_valid, 0);
    chk("bp_ready_back", in_ready, 1);
    chk("bp_res_kept", out_result, 16'h4400);
    chk("bp_cnt", txn_count, exp_cnt);

    // random transactions against the reference product
    for (int i = 0; i < 30; i++) begin
      ra_ = 16'($urandom);
      rb_ = 16'($urandom);
      e_ = fmul(ra_, rb_);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_txn(ra_, rb_, e_);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rnd_hold", out_result, e_);
      end
      consume(e_);
    end

    // reset while waiting (wait_cnt = 4 after D6)
    @(negedge clk);
    in_a = 16'h3C00;
    in_b = 16'h3C00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 16'h0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ui", dut_ui, 0);
    chk("rst_res", out_result, 0);
    chk("rst_cnt", txn_count, 0);
    begin
      int seen;
      seen = 0;
      repeat (15) begin
        @(negedge clk);
        if (out_valid || dut_ui != 8'h00) seen++;
      end
      chk("rst_no_result", seen, 0);
    end

    // counter wrap
    @(negedge clk);
    force dut.txn_count = 16'hFFFF;
    #1;
    release dut.txn_count;
    chk("preset_cnt", txn_count, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    run_txn(16'h3C00, 16'h3C00, 16'h3C00);
    chk("wrap_cnt", txn_count, 16'h0000);
    consume(16'h3C00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d want=0", 1);
    $fatal(1);
  end

endmodule
